// File: rtl/pps_timer_pkg.sv
// pps_timer_pkg: shared state encodings, error-counter constants and parameter defaults for pps_seconds_timer
package pps_timer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;
  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam int CLK_HZ_DEF = 256000000;
  localparam int TOL_DEF = 1024;
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pps_sync_edge.sv
// pps_sync_edge: 2-FF synchroniser plus registered rising-edge detector for the asynchronous 1PPS input
module pps_sync_edge (
  input  logic user_clk,
  input  logic user_rst,
  input  logic pps_in,
  output logic pps_edge
);
  logic meta_q, sync_q, prev_q, edge_q;
  logic meta_d, sync_d, prev_d, edge_d;
  always_comb begin
    meta_d = pps_in;
    sync_d = meta_q;
    prev_d = sync_q;
    edge_d = sync_q & ~prev_q;
  end
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end
  assign pps_edge = edge_q;
endmodule

// File: rtl/pps_seconds_timer.sv
// pps_seconds_timer: PPS-disciplined UTC seconds and sub-second cycle counter.
// Define PPS_FLYWHEEL_EN to keep counting seconds through missing PPS pulses.
module pps_seconds_timer
  import pps_timer_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int TOL    = TOL_DEF,
  parameter int CYC_W  = $clog2(CLK_HZ + TOL)
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic             pps_in,
  input  logic             arm,
  input  logic [31:0]      load_sec,
  input  logic             clr_err,
  output logic [31:0]      seconds_out,
  output logic [CYC_W-1:0] cycles_out,
  output logic             pps_tick,
  output logic             locked,
  output logic             pps_missing,
  output logic [ERR_W-1:0] err_cnt
);
  localparam logic [CYC_W-1:0] CYC_LO  = CYC_W'(CLK_HZ - 1 - TOL);
  localparam logic [CYC_W-1:0] CYC_HI  = CYC_W'(CLK_HZ - 1 + TOL);
  localparam logic [CYC_W-1:0] CYC_TOL = CYC_W'(TOL);
  logic pps_edge;
  state_e state_q, state_d;
  logic [31:0] sec_q, sec_d, ld_q, ld_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic tick_q, tick_d, locked_q, locked_d, miss_q, miss_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic glitch, miss_ev;
`ifndef PPS_FLYWHEEL_EN
  // Remembers that the current missing-PPS stall has already been reported.
  logic sat_q, sat_d;
`endif
  pps_sync_edge u_sync (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .pps_in   (pps_in),
    .pps_edge (pps_edge)
  );
  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    ld_d     = ld_q;
    cyc_d    = cyc_q;
    tick_d   = 1'b0;
    locked_d = locked_q;
    glitch   = 1'b0;
    miss_ev  = 1'b0;
`ifndef PPS_FLYWHEEL_EN
    sat_d    = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          ld_d    = load_sec;
        end
      end
      ARMED: begin
        if (arm) ld_d = load_sec;
        else if (pps_edge) begin
          state_d  = RUN;
          sec_d    = ld_q;
          cyc_d    = '0;
          tick_d   = 1'b1;
          locked_d = 1'b0;
`ifndef PPS_FLYWHEEL_EN
          sat_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        if (arm) begin
          state_d = ARMED;
          ld_d    = load_sec;
        end else if (pps_edge && cyc_q >= CYC_LO) begin
          // cyc_q never exceeds CYC_HI, so this is the whole acceptance window
          sec_d    = sec_q + 32'd1;
          cyc_d    = '0;
          tick_d   = 1'b1;
          locked_d = 1'b1;
`ifndef PPS_FLYWHEEL_EN
          sat_d    = 1'b0;
`endif
        end else begin
          glitch = pps_edge;
          if (cyc_q == CYC_HI) begin
            locked_d = 1'b0;
`ifdef PPS_FLYWHEEL_EN
            miss_ev = 1'b1;
            sec_d   = sec_q + 32'd1;
            tick_d  = 1'b1;
            cyc_d   = CYC_TOL;
`else
            miss_ev = ~sat_q;
            sat_d   = 1'b1;
`endif
          end else cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new error event outranks a coincident clear.
    err_d  = clr_err ? '0 : err_q;
    err_d  = (glitch | miss_ev) ? err_inc(err_d) : err_d;
    miss_d = (miss_q & ~clr_err) | miss_ev;
  end
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q  <= IDLE;
      sec_q    <= '0;
      ld_q     <= '0;
      cyc_q    <= '0;
      tick_q   <= 1'b0;
      locked_q <= 1'b0;
      miss_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      ld_q     <= ld_d;
      cyc_q    <= cyc_d;
      tick_q   <= tick_d;
      locked_q <= locked_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
    end
  end
`ifndef PPS_FLYWHEEL_EN
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) sat_q <= 1'b0;
    else sat_q <= sat_d;
  end
`endif
  assign seconds_out = sec_q;
  assign cycles_out  = cyc_q;
  assign pps_tick    = tick_q;
  assign locked      = locked_q;
  assign pps_missing = miss_q;
  assign err_cnt     = err_q;
endmodule

// File: tb/tb_pps_seconds_timer.sv
// tb_pps_seconds_timer: directed self-checking bench for pps_seconds_timer with CLK_HZ=100, TOL=4
module tb_pps_seconds_timer;
  localparam int CLK_HZ = 100;
  localparam int TOL = 4;
  localparam int CYC_W = $clog2(CLK_HZ + TOL);
  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  logic pps_in = 1'b0;
  logic arm = 1'b0;
  logic [31:0] load_sec = '0;
  logic clr_err = 1'b0;
  logic [31:0] seconds_out;
  logic [CYC_W-1:0] cycles_out;
  logic pps_tick, locked, pps_missing;
  logic [7:0] err_cnt;
  int n_vec = 0;
  int n_err = 0;
  pps_seconds_timer #(.CLK_HZ(CLK_HZ), .TOL(TOL)) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .pps_in      (pps_in),
    .arm         (arm),
    .load_sec    (load_sec),
    .clr_err     (clr_err),
    .seconds_out (seconds_out),
    .cycles_out  (cycles_out),
    .pps_tick    (pps_tick),
    .locked      (locked),
    .pps_missing (pps_missing),
    .err_cnt     (err_cnt)
  );
  always #5 user_clk = ~user_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " seconds"}, seconds_out, 32'd0);
    chk({tag, " cycles"}, 32'(cycles_out), 32'd0);
    chk({tag, " tick"}, 32'(pps_tick), 32'd0);
    chk({tag, " locked"}, 32'(locked), 32'd0);
    chk({tag, " missing"}, 32'(pps_missing), 32'd0);
    chk({tag, " err"}, 32'(err_cnt), 32'd0);
  endtask
  // Two-cycle PPS pulse; returns at the negedge where the resulting boundary is visible.
  task automatic pps_and_wait();
    pps_in = 1'b1;
    repeat (2) @(negedge user_clk);
    pps_in = 1'b0;
    repeat (2) @(negedge user_clk);
  endtask
  task automatic arm_with(input logic [31:0] v);
    arm = 1'b1;
    load_sec = v;
    @(negedge user_clk);
    arm = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge user_clk);
    chk_zero("reset");
    user_rst = 1'b0;
    @(negedge user_clk);
    for (int i = 0; i < 3; i++) begin
      pps_and_wait();
      repeat (3) @(negedge user_clk);
    end
    chk_zero("idle pps");
    arm_with(32'h10);
    chk("armed seconds", seconds_out, 32'd0);
    pps_and_wait();
    chk("arm tick", 32'(pps_tick), 32'd1);
    chk("arm seconds", seconds_out, 32'h10);
    chk("arm cycles", 32'(cycles_out), 32'd0);
    chk("arm locked", 32'(locked), 32'd0);
    repeat (96) @(negedge user_clk);
    chk("run cycles", 32'(cycles_out), 32'd96);
    chk("run tick low", 32'(pps_tick), 32'd0);
    pps_and_wait();
    chk("lock tick", 32'(pps_tick), 32'd1);
    chk("lock seconds", seconds_out, 32'h11);
    chk("lock cycles", 32'(cycles_out), 32'd0);
    chk("lock locked", 32'(locked), 32'd1);
    @(negedge user_clk);
    chk("tick one cycle", 32'(pps_tick), 32'd0);
    chk("post tick cycles", 32'(cycles_out), 32'd1);
    repeat (46) @(negedge user_clk);
    pps_and_wait();
    chk("glitch seconds", seconds_out, 32'h11);
    chk("glitch cycles", 32'(cycles_out), 32'd51);
    chk("glitch err", 32'(err_cnt), 32'd1);
    chk("glitch locked", 32'(locked), 32'd1);
    chk("glitch tick", 32'(pps_tick), 32'd0);
    repeat (52) @(negedge user_clk);
    chk("pre miss cycles", 32'(cycles_out), 32'd103);
    chk("pre miss flag", 32'(pps_missing), 32'd0);
    @(negedge user_clk);
    chk("miss flag", 32'(pps_missing), 32'd1);
    chk("miss locked", 32'(locked), 32'd0);
    chk("miss err", 32'(err_cnt), 32'd2);
`ifdef PPS_FLYWHEEL_EN
    chk("fly seconds", seconds_out, 32'h12);
    chk("fly cycles", 32'(cycles_out), 32'd4);
    chk("fly tick", 32'(pps_tick), 32'd1);
    repeat (5) @(negedge user_clk);
    chk("fly later cycles", 32'(cycles_out), 32'd9);
`else
    chk("hold seconds", seconds_out, 32'h11);
    chk("hold cycles", 32'(cycles_out), 32'd103);
    chk("hold tick", 32'(pps_tick), 32'd0);
    repeat (5) @(negedge user_clk);
    chk("hold later cycles", 32'(cycles_out), 32'd103);
`endif
    chk("miss err once", 32'(err_cnt), 32'd2);
    arm_with(32'hFFFF_FFFF);
    pps_and_wait();
    chk("rearm seconds", seconds_out, 32'hFFFF_FFFF);
    chk("rearm cycles", 32'(cycles_out), 32'd0);
    chk("rearm tick", 32'(pps_tick), 32'd1);
    chk("rearm locked", 32'(locked), 32'd0);
    repeat (96) @(negedge user_clk);
    pps_and_wait();
    chk("wrap seconds", seconds_out, 32'd0);
    chk("wrap tick", 32'(pps_tick), 32'd1);
    chk("wrap locked", 32'(locked), 32'd1);
    repeat (10) @(negedge user_clk);
    pps_in = 1'b1;
    repeat (2) @(negedge user_clk);
    pps_in = 1'b0;
    @(negedge user_clk);
    clr_err = 1'b1;
    @(negedge user_clk);
    clr_err = 1'b0;
    chk("clr vs glitch err", 32'(err_cnt), 32'd1);
    chk("clr vs glitch cycles", 32'(cycles_out), 32'd14);
    clr_err = 1'b1;
    @(negedge user_clk);
    clr_err = 1'b0;
    chk("clr err", 32'(err_cnt), 32'd0);
    chk("clr missing", 32'(pps_missing), 32'd0);
    chk("pre reset locked", 32'(locked), 32'd1);
    user_rst = 1'b1;
    #1;
    chk_zero("async reset");
    @(negedge user_clk);
    user_rst = 1'b0;
    pps_and_wait();
    repeat (2) @(negedge user_clk);
    chk_zero("post reset pps");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
